// File: rtl/spsram_double.sv
// 32x32 single-port SRAM built from two 16-bit banks sharing address and control.
// Read path: registered by default, combinational when SPSRAM_ASYNC_EN is defined.
module spsram_bank #(
    parameter int AWIDTH = 5,
    parameter int BWIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [BWIDTH-1:0] i_wdata,
    output logic [BWIDTH-1:0] o_rdata
);
    logic [BWIDTH-1:0] mem_q [2**AWIDTH];

    // Storage is deliberately not reset; unwritten words stay unknown.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];
endmodule

module spsram_double #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DWIDTH-1:0] i_data,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic              i_wen,
    input  logic              i_cen,
    input  logic              i_oen,
    output logic [DWIDTH-1:0] o_data
);
    localparam int HWIDTH = DWIDTH / 2;

    // Access protocol: no handshake; every cycle with i_cen=1 is one access,
    // a write when i_wen=1, otherwise a read gated by i_oen.
    logic              rd_en;
    logic              wr_en;
    logic [HWIDTH-1:0] bank0_rd;
    logic [HWIDTH-1:0] bank1_rd;
    logic [DWIDTH-1:0] word_rd;

    assign rd_en   = i_cen & ~i_wen & i_oen;
    assign wr_en   = i_cen & i_wen & ~i_rst;
    assign word_rd = {bank1_rd, bank0_rd};

    spsram_bank #(.AWIDTH(AWIDTH), .BWIDTH(HWIDTH)) u_bank0 (
        .i_clk   (i_clk),
        .i_we    (wr_en),
        .i_addr  (i_addr),
        .i_wdata (i_data[HWIDTH-1:0]),
        .o_rdata (bank0_rd)
    );

    spsram_bank #(.AWIDTH(AWIDTH), .BWIDTH(HWIDTH)) u_bank1 (
        .i_clk   (i_clk),
        .i_we    (wr_en),
        .i_addr  (i_addr),
        .i_wdata (i_data[DWIDTH-1:HWIDTH]),
        .o_rdata (bank1_rd)
    );

`ifdef SPSRAM_ASYNC_EN
    assign o_data = (rd_en && !i_rst) ? word_rd : '0;
`else
    logic [DWIDTH-1:0] out_d;
    logic [DWIDTH-1:0] out_q;

    always_comb begin
        out_d = '0;
        if (rd_en) begin
            out_d = word_rd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign o_data = out_q;
`endif
endmodule

// File: tb/tb_spsram_double.sv
// Self-checking bench for spsram_double: directed test plan plus random traffic
// against an array model; works in both SPSRAM_ASYNC_EN and registered builds.
module tb_spsram_double;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2**AW;

    // expectation kinds
    localparam logic [1:0] K_EXACT = 2'd0;
    localparam logic [1:0] K_NOT   = 2'd1;
    localparam logic [1:0] K_SKIP  = 2'd2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          wen;
    logic          cen;
    logic          oen;
    logic [DW-1:0] odata;

    logic [DW-1:0] exp_q[$];
    logic [1:0]    kind_q[$];
    string         name_q[$];

    logic [DW-1:0] mem_m [DEPTH];
    bit            known_m [DEPTH];

    int checks = 0;
    int errors = 0;

    spsram_double #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (data),
        .i_addr (addr),
        .i_wen  (wen),
        .i_cen  (cen),
        .i_oen  (oen),
        .o_data (odata)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One access cycle, driven at negedge; pushes the expected output for it.
    task automatic cycle(input bit r, input bit c, input bit w, input bit o,
                         input int a, input logic [DW-1:0] d, input string nm);
        logic [AW-1:0] wa;
        logic [DW-1:0] e;
        logic [1:0]    k;
        @(negedge clk);
        wa   = a[AW-1:0];
        rst  = r;
        cen  = c;
        wen  = w;
        oen  = o;
        addr = wa;
        data = d;
        e = '0;
        k = K_EXACT;
        if (!r && c && !w && o) begin
            if (known_m[wa]) begin
                e = mem_m[wa];
            end else begin
                e = 32'hDEAD_BEEF;
                k = (nm == "rst_write_blocked") ? K_NOT : K_SKIP;
            end
        end
        exp_q.push_back(e);
        kind_q.push_back(k);
        name_q.push_back(nm);
        if (!r && c && w) begin
            mem_m[wa]   = d;
            known_m[wa] = 1'b1;
        end
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input string nm);
        cycle(0, 1, 1, 0, a, d, nm);
    endtask

    task automatic rd(input int a, input string nm);
        cycle(0, 1, 0, 1, a, '0, nm);
    endtask

    // scoreboard monitor
    initial begin
        logic [DW-1:0] e;
        logic [1:0]    k;
        string         nm;
        forever begin
`ifdef SPSRAM_ASYNC_EN
            @(negedge clk);
            #2;
`else
            @(posedge clk);
            #1;
`endif
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                k  = kind_q.pop_front();
                nm = name_q.pop_front();
                if (k == K_EXACT) begin
                    checks++;
                    if (odata !== e) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", nm, odata, e);
                    end
                end else if (k == K_NOT) begin
                    checks++;
                    if (odata === e) begin
                        errors++;
                        $display("FAIL %s: got %h expected anything but %h", nm, odata, e);
                    end
                end
            end
        end
    end

    // driver
    initial begin
        int wait_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = '0;
        end
        rst = 1'b1; cen = 1'b0; wen = 1'b0; oen = 1'b0; addr = '0; data = '0;

        // reset holds output at 0 and blocks writes
        cycle(1, 1, 0, 1, 0, '0, "reset_out");
        cycle(1, 1, 0, 1, 0, '0, "reset_out");
        cycle(1, 1, 1, 1, 3, 32'hDEAD_BEEF, "reset_write");
        rd(3, "rst_write_blocked");

        // fill and read back
        for (int i = 0; i < DEPTH; i++) wr(i, i, "fill_wr");
        for (int i = 0; i < DEPTH; i++) rd(i, "fill_rd");

        // address wrap-around: last writer wins
        for (int i = 0; i < 100; i++) wr(i, i, "wrap_wr");
        for (int i = 0; i < DEPTH; i++) rd(i, "wrap_rd");

        // bank split
        wr(7, 32'hA5A5_5A5A, "bank_wr");
        wr(8, 32'h1234_5678, "bank_wr");
        rd(7, "bank_rd7");
        rd(8, "bank_rd8");

        // output gating
        wr(1, 32'hFFFF_FFFF, "gate_wr");
        cycle(0, 1, 0, 0, 1, '0, "gate_oen0");
        cycle(0, 0, 0, 1, 1, '0, "gate_cen0");
        cycle(0, 1, 1, 1, 1, '0, "gate_wen_oen");
        rd(1, "gate_rd_after");

        // alternating reads for latency
        wr(2, 2, "lat_wr");
        wr(5, 5, "lat_wr");
        for (int i = 0; i < 8; i++) rd((i % 2) ? 5 : 2, "lat_rd");

        // reset mid-stream keeps stored data
        rd(7, "mid_rd");
        cycle(1, 1, 0, 1, 7, '0, "mid_rst");
        rd(7, "mid_after_rst");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) < 8),
                  $urandom_range(0, DEPTH - 1),
                  $urandom(), "random");
        end

        // drain with a bounded wait
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
